rgb_pwm_mixer: RTL and testbench

Parametrised successor to the on/off RGB colour stepper. Steps through a colour table on a button press, drives each LED channel with a PWM duty, and adds a BREATHE mode that ramps brightness up and down. Sits between the board's debounced push-buttons and the active-low RGB LED pins. Button debouncing stays external, done by the existing debounce instance per button.

---
 rtl/rgb_pwm_mixer.sv | 165 ++++++++++++++++
 tb/tb_rgb_pwm_mixer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_mixer.sv
// Button-stepped colour table driving active-low RGB pins through per-channel PWM, with a BREATHE fade.
// Latency: button edge -> register 2 clk, register -> pin at next PWM period + 1 clk; free-running, no backpressure.
module rgb_pwm_mixer #(
  parameter int PWM_WIDTH  = 8,
  parameter int NUM_COLORS = 8,
  parameter int FADE_DIV   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       next_i,
  input  logic       mode_i,
  output logic       rLed_i,
  output logic       gLed_i,
  output logic       bLed_i,
  output logic [2:0] color_o,
  output logic       mode_o
);

  localparam logic [PWM_WIDTH-1:0] MAX      = {PWM_WIDTH{1'b1}};
  localparam logic [2:0]           LAST_IDX = 3'(NUM_COLORS - 1);
  localparam int                   PS_W     = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PS_W-1:0]      PS_LAST  = PS_W'(FADE_DIV - 1);

  typedef enum logic {STEADY = 1'b0, BREATHE = 1'b1} mode_t;
  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_t;

  logic [1:0] next_sync, mode_sync;
  logic       next_prev, mode_prev;
  logic [1:0] warm_cnt;
  logic       warm;
  logic       next_pulse, mode_pulse;

  mode_t                mode_q, mode_d;
  dir_t                 dir_q, dir_d;
  logic [PWM_WIDTH-1:0] bright_q, bright_d;
  logic [PS_W-1:0]      ps_q, ps_d;
  logic [2:0]           color_idx, color_d;

  logic [PWM_WIDTH-1:0] pwm_cnt, duty_q;
  logic [2:0]           color_q;
  logic [2:0]           led_on;
  logic                 tick;

  function automatic logic [2:0] color_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    color_rgb = 3'b000;
      3'd1:    color_rgb = 3'b100;
      3'd2:    color_rgb = 3'b010;
      3'd3:    color_rgb = 3'b001;
      3'd4:    color_rgb = 3'b110;
      3'd5:    color_rgb = 3'b011;
      3'd6:    color_rgb = 3'b101;
      default: color_rgb = 3'b111;
    endcase
  endfunction

  // Edges are only honoured once prev holds a real post-reset sample, so a button
  // already held at reset release does not count as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_sync <= 2'b00;
      mode_sync <= 2'b00;
      next_prev <= 1'b0;
      mode_prev <= 1'b0;
      warm_cnt  <= 2'd0;
    end else begin
      next_sync <= {next_sync[0], next_i};
      mode_sync <= {mode_sync[0], mode_i};
      next_prev <= next_sync[1];
      mode_prev <= mode_sync[1];
      if (!warm) warm_cnt <= warm_cnt + 2'd1;
    end
  end

  assign warm       = (warm_cnt == 2'd3);
  assign next_pulse = next_sync[1] & ~next_prev & warm;
  assign mode_pulse = mode_sync[1] & ~mode_prev & warm;
  assign tick       = (pwm_cnt == MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= STEADY;
      dir_q     <= DIR_DOWN;
      bright_q  <= MAX;
      ps_q      <= '0;
      color_idx <= 3'd0;
    end else begin
      mode_q    <= mode_d;
      dir_q     <= dir_d;
      bright_q  <= bright_d;
      ps_q      <= ps_d;
      color_idx <= color_d;
    end
  end

  always_comb begin
    color_d  = color_idx;
    mode_d   = mode_q;
    dir_d    = dir_q;
    bright_d = bright_q;
    ps_d     = ps_q;

    if (next_pulse) color_d = (color_idx == LAST_IDX) ? 3'd0 : color_idx + 3'd1;

    if (mode_pulse) begin
      ps_d = '0;
      if (mode_q == BREATHE) begin
        mode_d   = STEADY;
        bright_d = MAX;
        dir_d    = DIR_DOWN;
      end else begin
        mode_d = BREATHE;
      end
    end else if (mode_q == BREATHE && tick) begin
      if (ps_q == PS_LAST) begin
        ps_d = '0;
        // Triangle ramp: each end value is held for one step before turning.
        if (dir_q == DIR_DOWN) begin
          if (bright_q == '0) begin
            dir_d    = DIR_UP;
            bright_d = PWM_WIDTH'(1);
          end else begin
            bright_d = bright_q - PWM_WIDTH'(1);
          end
        end else begin
          if (bright_q == MAX) begin
            dir_d    = DIR_DOWN;
            bright_d = MAX - PWM_WIDTH'(1);
          end else begin
            bright_d = bright_q + PWM_WIDTH'(1);
          end
        end
      end else begin
        ps_d = ps_q + PS_W'(1);
      end
    end
  end

  // Duty and colour are latched only at the period boundary to avoid partial-period glitches.
  assign led_on = color_rgb(color_q) & {3{pwm_cnt < duty_q}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      duty_q  <= '0;
      color_q <= 3'd0;
      rLed_i  <= 1'b1;
      gLed_i  <= 1'b1;
      bLed_i  <= 1'b1;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_WIDTH'(1);
      if (tick) begin
        duty_q  <= bright_q;
        color_q <= color_idx;
      end
      rLed_i <= ~led_on[2];
      gLed_i <= ~led_on[1];
      bLed_i <= ~led_on[0];
    end
  end

  assign color_o = color_idx;
  assign mode_o  = mode_q;

endmodule

// File: tb/tb_rgb_pwm_mixer.sv
// Bench for rgb_pwm_mixer: instance A (W=4, 8 colours, FADE_DIV=2) tracked by a reference model,
// instance B (W=4, 5 colours) used for colour-wrap vectors.
module tb_rgb_pwm_mixer;

  localparam int MAXV = 15;
  localparam int PER  = 16;
  localparam int NC_A = 8;
  localparam int FD_A = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b1;
  logic       next_a = 1'b0, mode_a = 1'b0, next_b = 1'b0, mode_b = 1'b0;
  logic       r_a, g_a, b_a, r_b, g_b, b_b, mo_a, mo_b;
  logic [2:0] color_a, color_b;

  rgb_pwm_mixer #(.PWM_WIDTH(4), .NUM_COLORS(8), .FADE_DIV(2)) u_a (
    .clk(clk), .rst_n(rst_n), .next_i(next_a), .mode_i(mode_a),
    .rLed_i(r_a), .gLed_i(g_a), .bLed_i(b_a), .color_o(color_a), .mode_o(mo_a));

  rgb_pwm_mixer #(.PWM_WIDTH(4), .NUM_COLORS(5), .FADE_DIV(1)) u_b (
    .clk(clk), .rst_n(rst_n), .next_i(next_b), .mode_i(mode_b),
    .rLed_i(r_b), .gLed_i(g_b), .bLed_i(b_b), .color_o(color_b), .mode_o(mo_b));

  int n_checks = 0;
  int n_fail   = 0;

  // Colour table as {R,G,B} values.
  int rgb_tbl[8] = '{0, 4, 2, 1, 6, 3, 5, 7};

  // Reference model for instance A.
  bit         qn[$], qm[$];
  int         m_edges, m_color, m_bt, m_duty, m_cq;
  bit         m_mode;
  logic [2:0] m_led;

  typedef struct {
    logic lvl;
    int   hold;
    int   exp_color;
  } vec_t;

  function automatic int tri_wave(input int p);
    int q;
    q = p % (2 * MAXV);
    return (q <= MAXV) ? MAXV - q : q - MAXV;
  endfunction

  function automatic int cur_bright();
    return m_mode ? tri_wave(m_bt / FD_A) : MAXV;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    qn.delete();
    qm.delete();
    m_edges = 0;
    m_color = 0;
    m_mode  = 1'b0;
    m_bt    = 0;
    m_duty  = 0;
    m_cq    = 0;
    m_led   = 3'b111;
  endtask

  task automatic model_step();
    int         cnt;
    bit         tick, nev, mev;
    logic [2:0] bits;
    if (!rst_n) begin
      model_reset();
      return;
    end
    cnt   = m_edges % PER;
    bits  = 3'(rgb_tbl[m_cq]);
    m_led = (cnt < m_duty) ? ~bits : 3'b111;
    tick  = (cnt == PER - 1);
    if (tick) begin
      m_duty = cur_bright();
      m_cq   = m_color;
    end
    qn.push_back(next_a);
    qm.push_back(mode_a);
    if (qn.size() > 4) begin
      void'(qn.pop_front());
      void'(qm.pop_front());
    end
    // A press counts when the sample two edges back is high and the one before it low.
    nev = (qn.size() == 4) && qn[1] && !qn[0];
    mev = (qm.size() == 4) && qm[1] && !qm[0];
    if (nev) m_color = (m_color == NC_A - 1) ? 0 : m_color + 1;
    if (mev) begin
      m_mode = !m_mode;
      m_bt   = 0;
    end else if (tick && m_mode) begin
      m_bt++;
    end
    m_edges++;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
      check("cycle_a", int'({r_a, g_a, b_a, color_a, mo_a}),
            int'({m_led, 3'(m_color), m_mode}));
    end
  endtask

  task automatic pulse_next();
    next_a = 1'b1;
    cyc(3);
    next_a = 1'b0;
    cyc(3);
  endtask

  task automatic align();
    int guard;
    guard = 0;
    while ((m_edges % PER) != 0 && guard <= PER) begin
      cyc(1);
      guard++;
    end
  endtask

  initial begin
    vec_t vecs[11];
    int   lr, lg, lb, guard, low;
    int   vals[$], lens[$];

    vecs = '{'{1'b0, 4, 1}, '{1'b1, 4, 2}, '{1'b0, 4, 2}, '{1'b1, 4, 3},
             '{1'b0, 4, 3}, '{1'b1, 4, 4}, '{1'b0, 4, 4}, '{1'b1, 4, 0},
             '{1'b0, 4, 0}, '{1'b1, 4, 1}, '{1'b0, 4, 1}};
    model_reset();

    // Reset with next held high, then release while still high.
    next_a = 1'b1;
    next_b = 1'b1;
    #2 rst_n = 1'b0;
    cyc(3);
    check("reset_leds_a", int'({r_a, g_a, b_a}), 7);
    check("reset_leds_b", int'({r_b, g_b, b_b, mo_b}), 14);
    check("reset_color_b", int'(color_b), 0);
    rst_n = 1'b1;
    cyc(10);
    check("held_release_a", int'(color_a), 0);
    check("held_release_b", int'(color_b), 0);
    next_a = 1'b0;
    next_b = 1'b0;
    cyc(4);

    // Edge latency and wrap at NUM_COLORS=5.
    next_b = 1'b1;
    cyc(2);
    check("latency_k1", int'(color_b), 0);
    cyc(1);
    check("latency_k2", int'(color_b), 1);
    for (int i = 0; i < 11; i++) begin
      next_b = vecs[i].lvl;
      cyc(vecs[i].hold);
      check($sformatf("wrap_vec%0d", i), int'(color_b), vecs[i].exp_color);
    end

    // Colour change mid-period only shows after the next period boundary.
    pulse_next();
    cyc(20);
    align();
    lr = 0; lg = 0; lb = 0;
    for (int s = 0; s < PER; s++) begin
      if (s == 4) next_a = 1'b1;
      if (s == 8) next_a = 1'b0;
      cyc(1);
      lr += int'(!r_a); lg += int'(!g_a); lb += int'(!b_a);
    end
    check("glitch_red_p0", lr, 15);
    check("glitch_green_p0", lg, 0);
    check("glitch_blue_p0", lb, 0);
    lr = 0; lg = 0; lb = 0;
    for (int s = 0; s < PER; s++) begin
      cyc(1);
      lr += int'(!r_a); lg += int'(!g_a); lb += int'(!b_a);
    end
    check("glitch_red_p1", lr, 0);
    check("glitch_green_p1", lg, 15);
    check("glitch_blue_p1", lb, 0);
    check("glitch_color", int'(color_a), 2);

    // White, then BREATHE: per-period low counts follow the brightness triangle.
    repeat (5) pulse_next();
    cyc(20);
    check("white_color", int'(color_a), 7);
    align();
    for (int p = 0; p < 70; p++) begin
      low = 0;
      for (int s = 0; s < PER; s++) begin
        if (p == 0 && s == 0) mode_a = 1'b1;
        if (p == 0 && s == 3) mode_a = 1'b0;
        cyc(1);
        low += int'(!r_a);
      end
      if (vals.size() > 0 && vals[vals.size() - 1] == low)
        lens[lens.size() - 1] = lens[lens.size() - 1] + 1;
      else begin
        vals.push_back(low);
        lens.push_back(1);
      end
    end
    check("breathe_run_count", int'(vals.size() >= 32), 1);
    for (int i = 0; i < 32; i++)
      if (i < vals.size())
        check($sformatf("breathe_val%0d", i), vals[i],
              (i <= 15) ? 15 - i : ((i <= 30) ? i - 15 : 45 - i));
    for (int i = 1; i < 31; i++)
      if (i < lens.size()) check($sformatf("breathe_len%0d", i), lens[i], 2);

    // Simultaneous next and mode presses.
    next_a = 1'b1;
    mode_a = 1'b1;
    cyc(2);
    check("sim_hold", int'({color_a, mo_a}), 15);
    cyc(1);
    check("sim_color", int'(color_a), 0);
    check("sim_mode", int'(mo_a), 0);
    next_a = 1'b0;
    mode_a = 1'b0;
    cyc(3);
    pulse_next();
    cyc(20);
    align();
    lr = 0;
    for (int s = 0; s < PER; s++) begin
      cyc(1);
      lr += int'(!r_a);
    end
    check("steady_bright", lr, 15);

    // Asynchronous reset while breathing at brightness 6 with red lit.
    mode_a = 1'b1;
    cyc(3);
    mode_a = 1'b0;
    cyc(3);
    guard = 0;
    while (!(cur_bright() == 6 && m_led == 3'b011) && guard < 2000) begin
      cyc(1);
      guard++;
    end
    check("reach_bright6", int'(guard < 2000), 1);
    check("red_lit_pre_reset", int'(r_a), 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_leds", int'({r_a, g_a, b_a}), 7);
    check("mid_reset_color", int'(color_a), 0);
    check("mid_reset_mode", int'(mo_a), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    pulse_next();
    cyc(40);

    // Randomised button activity against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) next_a = ~next_a;
      if ($urandom_range(0, 40) == 0) mode_a = ~mode_a;
      cyc(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
